passcoder_led_serializer: RTL



---
 rtl/passcoder_led_serializer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/passcoder_led_serializer.sv
// Serialises NUM_SYM symbols of SYM_W bits onto one LED line: '1' is a long pulse, '0' a short one.
// Optional build macro PASSCODER_PARITY_EN appends an even-parity bit to every symbol.
module passcoder_led_serializer #(
  parameter int NUM_SYM       = 4,
  parameter int SYM_W         = 5,
  parameter int TICK_DIV      = 50000,
  parameter int SHORT_TICKS   = 1,
  parameter int LONG_TICKS    = 3,
  parameter int GAP_TICKS     = 1,
  parameter int SYM_GAP_TICKS = 3,
  localparam int IDX_W        = (NUM_SYM > 1) ? $clog2(NUM_SYM) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_SYM*SYM_W-1:0] sym_in,
  output logic                     LED_signal,
  output logic                     busy,
  output logic                     done,
  output logic [IDX_W-1:0]         sym_idx
);

`ifdef PASSCODER_PARITY_EN
  localparam int BITS = SYM_W + 1;
`else
  localparam int BITS = SYM_W;
`endif
  localparam int FRAME_W   = NUM_SYM * SYM_W;
  localparam int MAX_ON    = (LONG_TICKS > SHORT_TICKS) ? LONG_TICKS : SHORT_TICKS;
  localparam int MAX_OFF   = (SYM_GAP_TICKS > GAP_TICKS) ? SYM_GAP_TICKS : GAP_TICKS;
  localparam int MAX_TICKS = (MAX_ON > MAX_OFF) ? MAX_ON : MAX_OFF;
  localparam int CNT_W     = $clog2(MAX_TICKS) + 1;
  localparam int BIT_W     = $clog2(BITS + 1);
  localparam int PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {IDLE, ON, BGAP, SGAP, FIN} state_t;

  state_t             state;
  logic [FRAME_W-1:0] frame_q;
  logic [FRAME_W-1:0] nxt_frame;
  logic [SYM_W-1:0]   sym_sr;
  logic [BIT_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   dur;
  logic [PRE_W-1:0]   pre;
  logic               tick;
  logic               cur_bit;
  logic               last_tick;
  logic               last_bit;
  logic               last_sym;

  // frame_q[SYM_W-1:0] is always the symbol on air; sym_sr walks its bits MSB first.
  always_comb begin
    tick      = (pre == PRE_W'(TICK_DIV - 1));
    nxt_frame = frame_q >> SYM_W;
    last_bit  = (bit_cnt == BIT_W'(BITS - 1));
    last_sym  = (sym_idx == IDX_W'(NUM_SYM - 1));
`ifdef PASSCODER_PARITY_EN
    cur_bit   = (bit_cnt == BIT_W'(SYM_W)) ? ^frame_q[SYM_W-1:0] : sym_sr[SYM_W-1];
`else
    cur_bit   = sym_sr[SYM_W-1];
`endif
    case (state)
      ON:      dur = cur_bit ? CNT_W'(LONG_TICKS) : CNT_W'(SHORT_TICKS);
      BGAP:    dur = CNT_W'(GAP_TICKS);
      SGAP:    dur = CNT_W'(SYM_GAP_TICKS);
      default: dur = CNT_W'(1);
    endcase
    last_tick = tick && (cnt == dur - CNT_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      frame_q    <= '0;
      sym_sr     <= '0;
      bit_cnt    <= '0;
      cnt        <= '0;
      pre        <= '0;
      sym_idx    <= '0;
      LED_signal <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      done <= 1'b0;
      if (state != IDLE) pre <= tick ? '0 : pre + 1'b1;
      if (state == ON || state == BGAP || state == SGAP) begin
        if (tick) cnt <= last_tick ? '0 : cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            frame_q    <= sym_in;
            sym_sr     <= sym_in[SYM_W-1:0];
            pre        <= '0;
            cnt        <= '0;
            bit_cnt    <= '0;
            sym_idx    <= '0;
            LED_signal <= 1'b1;
            busy       <= 1'b1;
            in_ready   <= 1'b0;
            state      <= ON;
          end
        end
        ON: begin
          if (last_tick) begin
            LED_signal <= 1'b0;
            state      <= last_bit ? SGAP : BGAP;
          end
        end
        BGAP: begin
          if (last_tick) begin
            bit_cnt    <= bit_cnt + 1'b1;
            sym_sr     <= sym_sr << 1;
            LED_signal <= 1'b1;
            state      <= ON;
          end
        end
        SGAP: begin
          if (last_tick) begin
            if (last_sym) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              sym_idx    <= sym_idx + 1'b1;
              frame_q    <= nxt_frame;
              sym_sr     <= nxt_frame[SYM_W-1:0];
              bit_cnt    <= '0;
              LED_signal <= 1'b1;
              state      <= ON;
            end
          end
        end
        FIN: begin
          busy     <= 1'b0;
          in_ready <= 1'b1;
          sym_idx  <= '0;
          bit_cnt  <= '0;
          cnt      <= '0;
          pre      <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
